// File: rtl/led_framebuffer_if.sv
// Pixel link and scan-read bundle for the HUB75 framebuffer.
// master = MCU link plus scan driver, slave = framebuffer.
interface led_framebuffer_if #(
   parameter int COLS = 32,
   parameter int ROWS = 16
);
   localparam int RW = $clog2(ROWS / 2);
   localparam int CW = $clog2(COLS);

   logic          wr_valid;
   logic          wr_sof;
   logic [2:0]    wr_data;
   logic          wr_ready;
   logic          rd_en;
   logic [RW-1:0] rd_row;
   logic [CW-1:0] rd_col;
   logic [2:0]    rd_top;
   logic [2:0]    rd_bot;
   logic          rd_valid;

   modport master (
      output wr_valid, wr_sof, wr_data,
      output rd_en, rd_row, rd_col,
      input  wr_ready, rd_top, rd_bot, rd_valid
   );

   modport slave (
      input  wr_valid, wr_sof, wr_data,
      input  rd_en, rd_row, rd_col,
      output wr_ready, rd_top, rd_bot, rd_valid
   );
endinterface

// File: rtl/led_framebuffer.sv
// Double-buffered 32x16 RGB store; banks swap only on frame_done.
// Define FB_TEST_PATTERN_EN to show colour bars until the first swap.
module led_framebuffer #(
   parameter int COLS = 32,
   parameter int ROWS = 16
) (
   input  logic           clk,
   input  logic           areset,
   led_framebuffer_if.slave bus,
   input  logic           frame_done,
   output logic           swap_pending,
   output logic           front_sel
);
   localparam int PAIRS = ROWS / 2;
   localparam int DEPTH = PAIRS * COLS;
   localparam int NPIX  = ROWS * COLS;
   localparam int PW    = $clog2(NPIX);
   localparam int AW    = $clog2(DEPTH);

   typedef enum logic {FILL, FULL} state_t;

   state_t        state, state_n;
   logic [PW-1:0] wr_ptr, ptr_n;
   logic          pend_n, front_n;
   logic          wr_fire, swap;
   logic [PW-1:0] wa;
   logic          w_bot;
   logic [AW-1:0] widx, ridx;

   logic [2:0] mem_top [2*DEPTH];
   logic [2:0] mem_bot [2*DEPTH];

   assign bus.wr_ready = (state == FILL);
   assign wr_fire = bus.wr_valid && bus.wr_ready && areset;
   assign swap = (state == FULL) && frame_done && swap_pending;

   // Raster pointer folds onto the row-pair index; upper half goes to bottom array.
   assign wa    = bus.wr_sof ? '0 : wr_ptr;
   assign w_bot = (wa >= PW'(DEPTH));
   assign widx  = AW'(w_bot ? wa - PW'(DEPTH) : wa);
   assign ridx  = AW'(bus.rd_row) * AW'(COLS) + AW'(bus.rd_col);

   always_ff @(posedge clk) begin
      if (!areset) begin
         state        <= FILL;
         wr_ptr       <= '0;
         swap_pending <= 1'b0;
         front_sel    <= 1'b0;
      end else begin
         state        <= state_n;
         wr_ptr       <= ptr_n;
         swap_pending <= pend_n;
         front_sel    <= front_n;
      end
   end

   always_comb begin
      state_n = state;
      ptr_n   = wr_ptr;
      pend_n  = swap_pending;
      front_n = front_sel;
      unique case (state)
         FILL: begin
            if (bus.wr_valid) begin
               if (bus.wr_sof) begin
                  ptr_n = PW'(1);
               end else if (wr_ptr == PW'(NPIX - 1)) begin
                  ptr_n   = '0;
                  pend_n  = 1'b1;
                  state_n = FULL;
               end else begin
                  ptr_n = wr_ptr + PW'(1);
               end
            end
         end
         FULL: begin
            if (swap) begin
               front_n = ~front_sel;
               pend_n  = 1'b0;
               state_n = FILL;
            end
         end
         default: state_n = FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_fire) begin
         if (w_bot) mem_bot[{~front_sel, widx}] <= bus.wr_data;
         else       mem_top[{~front_sel, widx}] <= bus.wr_data;
      end
   end

`ifdef FB_TEST_PATTERN_EN
   logic       pat_en;
   logic [4:0] pcol;

   assign pcol = 5'(bus.rd_col);

   always_ff @(posedge clk) begin
      if (!areset)   pat_en <= 1'b1;
      else if (swap) pat_en <= 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!areset) begin
         bus.rd_valid <= 1'b0;
         bus.rd_top   <= '0;
         bus.rd_bot   <= '0;
      end else begin
         bus.rd_valid <= bus.rd_en;
         if (bus.rd_en && pat_en) begin
            bus.rd_top <= pcol[4:2];
            bus.rd_bot <= ~pcol[4:2];
         end else if (bus.rd_en) begin
            bus.rd_top <= mem_top[{front_sel, ridx}];
            bus.rd_bot <= mem_bot[{front_sel, ridx}];
         end
      end
   end
`else
   always_ff @(posedge clk) begin
      if (!areset) begin
         bus.rd_valid <= 1'b0;
         bus.rd_top   <= '0;
         bus.rd_bot   <= '0;
      end else begin
         bus.rd_valid <= bus.rd_en;
         if (bus.rd_en) begin
            bus.rd_top <= mem_top[{front_sel, ridx}];
            bus.rd_bot <= mem_bot[{front_sel, ridx}];
         end
      end
   end
`endif
endmodule

// File: tb/tb_led_framebuffer.sv
// Directed bench for led_framebuffer: fill, swap, restart, back-pressure.
// Inputs change and outputs are sampled on the falling edge.
module tb_led_framebuffer;
   localparam int COLS = 32;
   localparam int ROWS = 16;

   logic clk = 1'b0;
   logic areset = 1'b0;
   logic frame_done = 1'b0;
   logic swap_pending, front_sel;
   int total = 0;
   int bad = 0;

   led_framebuffer_if #(.COLS(COLS), .ROWS(ROWS)) bus ();

   led_framebuffer #(.COLS(COLS), .ROWS(ROWS)) dut (
      .clk(clk),
      .areset(areset),
      .bus(bus),
      .frame_done(frame_done),
      .swap_pending(swap_pending),
      .front_sel(front_sel)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] pix(input int sel, input int i);
      case (sel)
         0:       return 3'(i % 8);
         1:       return 3'((i + i / 32 + (i / 256) * 3) % 8);
         default: return 3'((i * 3 + 1) % 8);
      endcase
   endfunction

   task automatic wr_px(input logic sof, input logic [2:0] d,
                        input logic fd);
      bus.wr_valid = 1'b1;
      bus.wr_sof   = sof;
      bus.wr_data  = d;
      frame_done   = fd;
      @(negedge clk);
      bus.wr_valid = 1'b0;
      bus.wr_sof   = 1'b0;
      frame_done   = 1'b0;
   endtask

   task automatic wr_run(input int sel, input int from, input int to,
                         input logic sof_first, input int fd_at);
      for (int i = from; i <= to; i++)
         wr_px(sof_first && i == from, pix(sel, i), i == fd_at);
   endtask

   task automatic pulse_fd();
      frame_done = 1'b1;
      @(negedge clk);
      frame_done = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input int row, input int col,
                         input int et, input int eb);
      bus.rd_en  = 1'b1;
      bus.rd_row = 3'(row);
      bus.rd_col = 5'(col);
      @(negedge clk);
      bus.rd_en = 1'b0;
      chk({tag, "_v"}, 32'(bus.rd_valid), 1);
      chk({tag, "_t"}, 32'(bus.rd_top), et);
      chk({tag, "_b"}, 32'(bus.rd_bot), eb);
   endtask

   initial begin
      bus.wr_valid = 1'b0;
      bus.wr_sof   = 1'b0;
      bus.wr_data  = '0;
      bus.rd_en    = 1'b0;
      bus.rd_row   = '0;
      bus.rd_col   = '0;

      repeat (2) @(negedge clk);
      areset = 1'b1;
      chk("rst_ready", 32'(bus.wr_ready), 1);
      chk("rst_pend", 32'(swap_pending), 0);
      chk("rst_front", 32'(front_sel), 0);
      chk("rst_valid", 32'(bus.rd_valid), 0);
      chk("rst_top", 32'(bus.rd_top), 0);
      chk("rst_bot", 32'(bus.rd_bot), 0);

`ifdef FB_TEST_PATTERN_EN
      rd_chk("pat12", 0, 12, 3, 4);
`endif

      // Frame A, last pixel alone, then swap
      wr_run(0, 0, 510, 1'b1, -1);
      chk("a511_ready", 32'(bus.wr_ready), 1);
      wr_run(0, 511, 511, 1'b0, -1);
      chk("a_full_ready", 32'(bus.wr_ready), 0);
      chk("a_full_pend", 32'(swap_pending), 1);
      chk("a_full_front", 32'(front_sel), 0);
      pulse_fd();
      chk("a_swap_front", 32'(front_sel), 1);
      chk("a_swap_ready", 32'(bus.wr_ready), 1);
      chk("a_swap_pend", 32'(swap_pending), 0);
      rd_chk("a_r3c5", 3, 5, 5, 5);

      // Back-to-back reads then an idle cycle that must hold data
      bus.rd_en  = 1'b1;
      bus.rd_row = 3'd0;
      bus.rd_col = 5'd2;
      @(negedge clk);
      chk("b2b0_t", 32'(bus.rd_top), 2);
      bus.rd_row = 3'd7;
      bus.rd_col = 5'd30;
      @(negedge clk);
      bus.rd_en = 1'b0;
      chk("b2b1_v", 32'(bus.rd_valid), 1);
      chk("b2b1_t", 32'(bus.rd_top), 6);
      @(negedge clk);
      chk("idle_v", 32'(bus.rd_valid), 0);
      chk("idle_hold", 32'(bus.rd_top), 6);

      // Frame B: stray frame_done mid-fill, last write coincides with frame_done
      wr_run(1, 0, 299, 1'b1, 200);
      chk("b_fd_fill_front", 32'(front_sel), 1);
      rd_chk("b_mid_r3c5", 3, 5, 5, 5);
      wr_run(1, 300, 510, 1'b0, -1);
      wr_px(1'b0, pix(1, 511), 1'b1);
      chk("b_same_front", 32'(front_sel), 1);
      chk("b_same_pend", 32'(swap_pending), 1);
      chk("b_same_ready", 32'(bus.wr_ready), 0);

      // Back-pressure in FULL
      bus.wr_valid = 1'b1;
      bus.wr_data  = 3'd2;
      repeat (10) @(negedge clk);
      bus.wr_valid = 1'b0;
      chk("bp_ready", 32'(bus.wr_ready), 0);
      chk("bp_front", 32'(front_sel), 1);
      pulse_fd();
      chk("b_swap_front", 32'(front_sel), 0);
      chk("b_swap_ready", 32'(bus.wr_ready), 1);
      rd_chk("b_r3c5", 3, 5, 0, 3);
      rd_chk("b_r7c31", 7, 31, 6, 1);
      rd_chk("b_r0c0", 0, 0, 0, 3);

      // Frame C with no sof: pointer must still start at 0
      wr_run(2, 0, 510, 1'b0, -1);
      chk("c511_ready", 32'(bus.wr_ready), 1);
      chk("c511_pend", 32'(swap_pending), 0);
      wr_run(2, 511, 511, 1'b0, -1);
      chk("c_full_ready", 32'(bus.wr_ready), 0);
      pulse_fd();
      chk("c_swap_front", 32'(front_sel), 1);
      rd_chk("c_r0c0", 0, 0, 1, 1);
      rd_chk("c_r2c9", 2, 9, 4, 4);

      // Frame D: 100 pixels then restart with sof value 7
      wr_run(0, 0, 99, 1'b1, -1);
      wr_px(1'b1, 3'd7, 1'b0);
      wr_run(1, 1, 510, 1'b0, -1);
      chk("d510_ready", 32'(bus.wr_ready), 1);
      chk("d510_pend", 32'(swap_pending), 0);
      wr_run(1, 511, 511, 1'b0, -1);
      chk("d_full_ready", 32'(bus.wr_ready), 0);
      chk("d_full_pend", 32'(swap_pending), 1);
      pulse_fd();
      chk("d_swap_front", 32'(front_sel), 0);
      rd_chk("d_r0c0", 0, 0, 7, 3);
      rd_chk("d_r3c5", 3, 5, 0, 3);

      // Reset while FULL drops the pending swap
      wr_run(0, 0, 511, 1'b1, -1);
      chk("e_full_pend", 32'(swap_pending), 1);
      areset = 1'b0;
      @(negedge clk);
      areset = 1'b1;
      chk("e_rst_pend", 32'(swap_pending), 0);
      chk("e_rst_ready", 32'(bus.wr_ready), 1);
      pulse_fd();
      chk("e_fd_front", 32'(front_sel), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
